// File: rtl/polaris_bus_pkg.sv
// Shared definitions for the two-master external bus arbiter.
package polaris_bus_pkg;

  // Grant FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  // Bus size codes; 3 is reserved but still counts as a request.
  localparam logic [1:0] SIZE_IDLE  = 2'd0;
  localparam logic [1:0] SIZE_BYTE  = 2'd1;
  localparam logic [1:0] SIZE_HWORD = 2'd2;

  // Master identifiers, used for the most-recently-served record.
  typedef enum logic {
    MST_I = 1'b0,
    MST_D = 1'b1
  } mst_e;

  // gnt_o encodings.
  localparam logic [1:0] GNTO_NONE = 2'b00;
  localparam logic [1:0] GNTO_I    = 2'b01;
  localparam logic [1:0] GNTO_D    = 2'b10;

endpackage

// File: rtl/bus_watchdog.sv
// Wait-state counter that flags a transfer the bus never acknowledges.
// TIMEOUT = 0 disables the watchdog entirely.
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic expire_o
);

  localparam int              CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // Count unacknowledged cycles, saturating at the limit so it never wraps.
  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i)
      cnt <= '0;
    else if (cnt_en_i && (cnt != LIMIT))
      cnt <= cnt + 1'b1;
  end

  assign expire_o = (TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter sharing the external bus between fetch (I) and
// load/store (D), with alternating priority on ties and lock support.
module bus_arbiter
  import polaris_bus_pkg::*;
#(
  parameter int ADR_W   = 64,
  parameter int DAT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [ADR_W-1:0] i_adr_i,
  input  logic [1:0]       i_size_i,
  input  logic             i_lock_i,
  output logic             i_ack_o,
  output logic             i_err_o,
  input  logic [ADR_W-1:0] d_adr_i,
  input  logic [1:0]       d_size_i,
  input  logic             d_we_i,
  input  logic [DAT_W-1:0] d_dat_i,
  input  logic             d_lock_i,
  output logic             d_ack_o,
  output logic             d_err_o,
  output logic [DAT_W-1:0] dat_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [1:0]       size_o,
  output logic             we_o,
  output logic [DAT_W-1:0] bdat_o,
  input  logic             ack_i,
  input  logic [DAT_W-1:0] dat_i,
  output logic [1:0]       gnt_o
);

  arb_state_e state, state_nxt;
  mst_e       last, last_nxt;

  logic i_req, d_req;
  logic owned, x_req, x_lock, oth_req;
  logic expire, timed_out, release_pt;
  logic wd_clr, wd_en;

  assign i_req = (i_size_i != SIZE_IDLE);
  assign d_req = (d_size_i != SIZE_IDLE);

  // Qualifiers for whichever master currently owns the bus.
  always_comb begin
    owned      = (state != IDLE);
    x_req      = (state == GNT_D) ? d_req : i_req;
    x_lock     = (state == GNT_D) ? d_lock_i : i_lock_i;
    oth_req    = (state == GNT_D) ? i_req : d_req;
    // Only an active request can time out; a locked idle owner just holds.
    timed_out  = owned && x_req && expire;
    release_pt = owned && !x_lock && (ack_i || !x_req);
  end

  // Next grant and most-recently-served master.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (i_req && (!d_req || (last == MST_D)))
          state_nxt = GNT_I;
        else if (d_req)
          state_nxt = GNT_D;
      end
      GNT_I: begin
        if (timed_out) begin
          state_nxt = IDLE;
          last_nxt  = MST_I;
        end else if (release_pt) begin
          last_nxt  = MST_I;
          state_nxt = oth_req ? GNT_D : (x_req ? GNT_I : IDLE);
        end
      end
      GNT_D: begin
        if (timed_out) begin
          state_nxt = IDLE;
          last_nxt  = MST_D;
        end else if (release_pt) begin
          last_nxt  = MST_D;
          state_nxt = oth_req ? GNT_I : (x_req ? GNT_D : IDLE);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant state register; reset favours I on the first tie.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      last  <= MST_D;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Count only genuine wait states; any ack, idle size or grant change restarts.
  assign wd_en  = owned && x_req && !ack_i;
  assign wd_clr = !owned || !x_req || ack_i || (state_nxt != state);

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clr_i    (wd_clr),
    .cnt_en_i (wd_en),
    .expire_o (expire)
  );

  // Bus and response muxing; everything quiet while in reset or idle.
  always_comb begin
    adr_o   = '0;
    size_o  = SIZE_IDLE;
    we_o    = 1'b0;
    bdat_o  = '0;
    i_ack_o = 1'b0;
    i_err_o = 1'b0;
    d_ack_o = 1'b0;
    d_err_o = 1'b0;
    gnt_o   = GNTO_NONE;
    dat_o   = dat_i;
    if (!reset_i) begin
      case (state)
        GNT_I: begin
          adr_o   = i_adr_i;
          size_o  = timed_out ? SIZE_IDLE : i_size_i;
          i_ack_o = ack_i && !timed_out;
          i_err_o = timed_out;
          gnt_o   = GNTO_I;
        end
        GNT_D: begin
          adr_o   = d_adr_i;
          size_o  = timed_out ? SIZE_IDLE : d_size_i;
          we_o    = d_we_i;
          bdat_o  = d_dat_i;
          d_ack_o = ack_i && !timed_out;
          d_err_o = timed_out;
          gnt_o   = GNTO_D;
        end
        default: ;
      endcase
    end
  end

endmodule
